// File: rtl/fft_ctrl_pkg.sv
// Shared types and constants for the FFT input-side stream controller.
//   state_e : controller FSM states (IDLE, RUN, ERR)
//   tag_t   : framing tag that travels alongside each sample through the
//             datapath latency: {valid, sop, eop, par}
//   NPT_DEF, LOG2_NPT : default frame length and its counter width
package fft_ctrl_pkg;

  localparam int NPT_DEF  = 16;
  localparam int LOG2_NPT = $clog2(NPT_DEF);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_ERR  = 2'd2
  } state_e;

  typedef struct packed {
    logic valid;
    logic sop;
    logic eop;
    logic par;   // frame parity, used to kill the tags of an aborted frame
  } tag_t;

endpackage

// File: rtl/fft_tag_delay.sv
// DEPTH-deep shift register of framing tags that mirrors the datapath
// latency. A tag whose parity matches clr_par_i is dropped while clr_i is
// high, both for tags already in flight and for the tag entering that cycle.
// Ports:
//   clk, reset    : clock, asynchronous active-high reset
//   tag_i         : tag entering stage 0
//   clr_i         : kill tags whose parity equals clr_par_i
//   clr_par_i     : parity of the frame being killed
//   tag_o         : tag leaving the last stage
//   any_valid_o   : at least one stage holds a valid tag
module fft_tag_delay
  import fft_ctrl_pkg::*;
#(
  parameter int DEPTH = 24
) (
  input  logic clk,
  input  logic reset,
  input  tag_t tag_i,
  input  logic clr_i,
  input  logic clr_par_i,
  output tag_t tag_o,
  output logic any_valid_o
);

  tag_t stage_q [DEPTH];
  tag_t stage_d [DEPTH];

  // A killed tag is zeroed entirely so sop/eop never leak out unqualified.
  function automatic tag_t scrub(tag_t t, logic clr, logic p);
    scrub = t;
    if (clr && (t.par == p)) scrub = '0;
  endfunction

  // NOTE: every variable driven here gets a value before any condition is
  // evaluated, so no path leaves it holding its old value (no latch).
  always_comb begin
    any_valid_o = 1'b0;
    stage_d[0]  = scrub(tag_i, clr_i, clr_par_i);
    for (int i = 1; i < DEPTH; i++) begin
      stage_d[i] = scrub(stage_q[i-1], clr_i, clr_par_i);
    end
    for (int i = 0; i < DEPTH; i++) begin
      any_valid_o = any_valid_o | stage_q[i].valid;
    end
  end

  // NOTE: this array carries control (valid bits), not bulk data, so it must
  // be reset; a stale valid after reset would emit phantom output framing.
  // NOTE: sequential state uses non-blocking assignments so every stage
  // samples the pre-edge value of its neighbour.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) stage_q[i] <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) stage_q[i] <= stage_d[i];
    end
  end

  assign tag_o = stage_q[DEPTH-1];

endmodule

// File: rtl/fft_stream_ctrl.sv
// Input-side sequencer for the pipelined FFT datapath. Accepts a serial
// sample stream (valid/ready + sop), registers samples into the datapath,
// issues the combinational start pulse that aligns the remap/commutator
// counters to sample 0, and regenerates output framing through a
// latency-matched tag pipeline. Underrun or mid-frame resync aborts the
// frame and kills its in-flight tags.
// Ports:
//   clk, reset           : clock, asynchronous active-high reset
//   in_data/valid/sop    : sample stream in;  in_ready : accepted this cycle
//   dp_data/dp_valid     : registered sample to the datapath
//   dp_start             : combinational frame start to remap stages
//   out_valid/sop/eop    : framing for the datapath output word
//   frame_cnt            : completed input frames (wraps)
//   err_pulse, err_cnt   : abort indication and saturating abort count
//   busy                 : not idle, or framing tags still in flight
module fft_stream_ctrl
  import fft_ctrl_pkg::*;
#(
  parameter int NB       = 32,
  parameter int NPT      = NPT_DEF,
  parameter int PIPE_LAT = 24
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [NB-1:0] in_data,
  input  logic          in_valid,
  input  logic          in_sop,
  output logic          in_ready,
  output logic [NB-1:0] dp_data,
  output logic          dp_valid,
  output logic          dp_start,
  output logic          out_valid,
  output logic          out_sop,
  output logic          out_eop,
  output logic [15:0]   frame_cnt,
  output logic          err_pulse,
  output logic [7:0]    err_cnt,
  output logic          busy
);

  localparam int            CW   = $clog2(NPT);
  localparam logic [CW-1:0] LAST = CW'(NPT - 1);

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          par_q, par_d;
  logic          ready_q;
  logic [NB-1:0] data_q;
  logic          dp_valid_q;
  logic [15:0]   frame_q, frame_d;
  logic          err_pulse_q;
  logic [7:0]    err_cnt_q, err_cnt_d;
  tag_t          tag_q, tag_d;
  tag_t          tag_out;
  logic          tags_live;

  logic          accept;
  logic          load;     // sample goes to the datapath this cycle
  logic          abort;
  logic [CW-1:0] idx;      // frame position of the sample being loaded

  assign accept = in_valid & in_ready;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    par_d     = par_q;
    load      = 1'b0;
    abort     = 1'b0;
    dp_start  = 1'b0;
    idx       = cnt_q;
    tag_d     = '0;
    frame_d   = frame_q;
    err_cnt_d = err_cnt_q;

    unique case (state_q)
      S_IDLE: begin
        // Non-sop samples in IDLE are accepted and silently dropped.
        if (accept && in_sop) begin
          dp_start = 1'b1;
          par_d    = ~par_q;
          idx      = '0;
          load     = 1'b1;
          state_d  = S_RUN;
        end
      end
      S_RUN: begin
        if (cnt_q == '0) begin
          // Frame boundary: a gap here is a clean return to IDLE.
          if (!in_valid) begin
            state_d = S_IDLE;
          end else if (in_sop) begin
            dp_start = 1'b1;
            par_d    = ~par_q;
            load     = 1'b1;
          end else begin
            abort = 1'b1;
          end
        end else begin
          if (!in_valid || in_sop) abort = 1'b1;
          else                     load  = 1'b1;
        end
      end
      S_ERR: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (load) begin
      // NPT is a power of two, so the counter wraps to 0 on its own.
      cnt_d       = idx + CW'(1);
      tag_d.valid = 1'b1;
      tag_d.sop   = (idx == '0);
      tag_d.eop   = (idx == LAST);
      tag_d.par   = par_d;
      if (idx == LAST) frame_d = frame_q + 16'd1;
    end

    if (abort) begin
      cnt_d   = '0;
      state_d = S_ERR;
      if (err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      par_q       <= 1'b0;
      ready_q     <= 1'b0;
      data_q      <= '0;
      dp_valid_q  <= 1'b0;
      tag_q       <= '0;
      frame_q     <= '0;
      err_pulse_q <= 1'b0;
      err_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      par_q       <= par_d;
      // Ready is low during reset and for the single ERR cycle only.
      ready_q     <= (state_d != S_ERR);
      if (load) data_q <= in_data;
      dp_valid_q  <= load;
      tag_q       <= tag_d;
      frame_q     <= frame_d;
      err_pulse_q <= abort;
      err_cnt_q   <= err_cnt_d;
    end
  end

  // tag_q sits alongside dp_valid, so PIPE_LAT further stages put the tag at
  // the output exactly PIPE_LAT cycles after dp_valid. tag_q is the tag
  // "entering" the pipeline and is scrubbed together with the stages.
  fft_tag_delay #(.DEPTH(PIPE_LAT)) u_tag_delay (
    .clk         (clk),
    .reset       (reset),
    .tag_i       (tag_q),
    .clr_i       (abort),
    .clr_par_i   (par_q),
    .tag_o       (tag_out),
    .any_valid_o (tags_live)
  );

  assign in_ready  = ready_q;
  assign dp_data   = data_q;
  assign dp_valid  = dp_valid_q;
  assign out_valid = tag_out.valid;
  assign out_sop   = tag_out.sop;
  assign out_eop   = tag_out.eop;
  assign frame_cnt = frame_q;
  assign err_pulse = err_pulse_q;
  assign err_cnt   = err_cnt_q;
  assign busy      = (state_q != S_IDLE) | tag_q.valid | tags_live;

endmodule

// File: tb/tb_fft_stream_ctrl.sv
// Self-checking bench for fft_stream_ctrl: directed scenarios followed by a
// randomized stream, all checked every cycle against a behavioural model
// that schedules expected output framing by absolute cycle number.
module tb_fft_stream_ctrl;

  localparam int NB  = 32;
  localparam int NPT = 16;
  localparam int LAT = 24;
  localparam int SCH = 4096;

  logic          clk = 1'b0;
  logic          reset;
  logic [NB-1:0] in_data;
  logic          in_valid, in_sop, in_ready;
  logic [NB-1:0] dp_data;
  logic          dp_valid, dp_start;
  logic          out_valid, out_sop, out_eop;
  logic [15:0]   frame_cnt;
  logic          err_pulse;
  logic [7:0]    err_cnt;
  logic          busy;

  fft_stream_ctrl #(.NB(NB), .NPT(NPT), .PIPE_LAT(LAT)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_sop    (in_sop),
    .in_ready  (in_ready),
    .dp_data   (dp_data),
    .dp_valid  (dp_valid),
    .dp_start  (dp_start),
    .out_valid (out_valid),
    .out_sop   (out_sop),
    .out_eop   (out_eop),
    .frame_cnt (frame_cnt),
    .err_pulse (err_pulse),
    .err_cnt   (err_cnt),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Model: stream mode (0 idle, 1 in frame, 2 error recovery), position in
  // frame, frame parity, expected register outputs, and a schedule of
  // expected output tags indexed by the cycle they appear.
  int            mode, pos, fcnt, ecnt;
  bit            par, epulse, edv, rdy;
  logic [NB-1:0] edd;
  bit            sv [SCH];
  bit            ss [SCH];
  bit            se [SCH];
  bit            sp [SCH];

  // Observed-event tallies for scenario-level checks.
  int n_start, n_dpv, n_outv, n_osop, n_oeop, n_err, n_nrdy;
  int st_q [$];

  task automatic check(string tag, logic [31:0] got, logic [31:0] want);
    total++;
    assert (got === want)
    else begin
      bad++;
      $error("FAIL %s: got %0h want %0h at cycle %0d", tag, got, want, cyc);
    end
  endtask

  task automatic clr_counts();
    n_start = 0; n_dpv = 0; n_outv = 0; n_osop = 0; n_oeop = 0;
    n_err = 0; n_nrdy = 0;
    st_q.delete();
  endtask

  // One clock cycle: drive inputs, check everything at the falling edge,
  // then advance the model by the rules of the stream protocol.
  task automatic step(bit v, bit s, logic [NB-1:0] d);
    bit acc, st, ld, ab, any;
    int idx, k, j;
    in_valid = v;
    in_sop   = s;
    in_data  = d;
    @(negedge clk);
    acc = v && rdy;
    st  = acc && s && (mode == 0 || (mode == 1 && pos == 0));
    any = 1'b0;
    for (int m = 0; m <= LAT; m++) if (sv[(cyc + m) % SCH]) any = 1'b1;

    check("in_ready",  in_ready,  rdy);
    check("dp_start",  dp_start,  st);
    check("dp_valid",  dp_valid,  edv);
    if (edv) check("dp_data", dp_data, edd);
    check("out_valid", out_valid, sv[cyc % SCH]);
    check("out_sop",   out_sop,   ss[cyc % SCH]);
    check("out_eop",   out_eop,   se[cyc % SCH]);
    check("frame_cnt", frame_cnt, fcnt);
    check("err_pulse", err_pulse, epulse);
    check("err_cnt",   err_cnt,   ecnt);
    check("busy",      busy,      (mode != 0) || any);

    n_start += int'(dp_start);
    n_dpv   += int'(dp_valid);
    n_outv  += int'(out_valid);
    n_osop  += int'(out_sop);
    n_oeop  += int'(out_eop);
    n_err   += int'(err_pulse);
    n_nrdy  += int'(!in_ready);
    if (dp_start) st_q.push_back(cyc);

    sv[cyc % SCH] = 0; ss[cyc % SCH] = 0; se[cyc % SCH] = 0;
    ld = 0; ab = 0; idx = 0;
    case (mode)
      0: if (acc && s) begin par = !par; ld = 1; mode = 1; end
      1: begin
        if (pos == 0) begin
          if (!v)     mode = 0;
          else if (s) begin par = !par; ld = 1; end
          else        ab = 1;
        end else begin
          if (!v || s) ab = 1;
          else begin idx = pos; ld = 1; end
        end
      end
      default: mode = 0;
    endcase
    if (ld) begin
      k = (cyc + 1 + LAT) % SCH;
      sv[k] = 1; ss[k] = (idx == 0); se[k] = (idx == NPT - 1); sp[k] = par;
      pos = (idx + 1) % NPT;
      if (idx == NPT - 1) fcnt = (fcnt + 1) % 65536;
      edd = d;
    end
    edv    = ld;
    epulse = ab;
    if (ab) begin
      if (ecnt < 255) ecnt++;
      for (int m = 1; m <= LAT; m++) begin
        j = (cyc + m) % SCH;
        if (sv[j] && sp[j] == par) begin sv[j] = 0; ss[j] = 0; se[j] = 0; end
      end
      pos  = 0;
      mode = 2;
    end
    rdy = (mode != 2);
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    reset = 1'b1; in_valid = 1'b0; in_sop = 1'b0; in_data = '0;
    #1;
    check("rst_in_ready",  in_ready,  0);
    check("rst_dp_valid",  dp_valid,  0);
    check("rst_dp_data",   dp_data,   0);
    check("rst_dp_start",  dp_start,  0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_sop",   out_sop,   0);
    check("rst_out_eop",   out_eop,   0);
    check("rst_frame_cnt", frame_cnt, 0);
    check("rst_err_pulse", err_pulse, 0);
    check("rst_err_cnt",   err_cnt,   0);
    check("rst_busy",      busy,      0);
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b0;
    mode = 0; pos = 0; par = 0; fcnt = 0; ecnt = 0;
    epulse = 0; edv = 0; edd = '0; rdy = 0;
    for (int i = 0; i < SCH; i++) begin sv[i] = 0; ss[i] = 0; se[i] = 0; sp[i] = 0; end
    step(0, 0, '0);   // ready is still low in the first cycle after release
  endtask

  task automatic frame(logic [NB-1:0] base, int n);
    for (int i = 0; i < n; i++) step(1, i == 0, base + NB'(i));
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) step(0, 0, '0);
  endtask

  initial begin
    int kind, len;

    // Reset state, then one contiguous frame of values 0..15.
    do_reset();
    clr_counts();
    frame('0, NPT);
    idle(LAT + 4);
    check("f1_starts",  n_start, 1);
    check("f1_dpvalid", n_dpv,   16);
    check("f1_outv",    n_outv,  16);
    check("f1_osop",    n_osop,  1);
    check("f1_oeop",    n_oeop,  1);
    check("f1_frames",  frame_cnt, 1);

    // Three back-to-back frames.
    do_reset();
    clr_counts();
    frame(32'h10, NPT); frame(32'h20, NPT); frame(32'h30, NPT);
    idle(LAT + 4);
    check("b2b_starts", n_start, 3);
    if (st_q.size() == 3) begin
      check("b2b_gap1", st_q[1] - st_q[0], NPT);
      check("b2b_gap2", st_q[2] - st_q[1], NPT);
    end
    check("b2b_frames", frame_cnt, 3);
    check("b2b_osop",   n_osop, 3);
    check("b2b_oeop",   n_oeop, 3);
    check("b2b_errs",   err_cnt, 0);

    // Underrun at sample 9 of frame 2.
    do_reset();
    clr_counts();
    frame(32'h100, NPT);
    frame(32'h200, 9);
    idle(LAT + 4);
    check("ur_pulses", n_err, 1);
    check("ur_errcnt", err_cnt, 1);
    check("ur_nrdy",   n_nrdy, 1);
    check("ur_outv",   n_outv, 16);
    check("ur_osop",   n_osop, 1);
    check("ur_oeop",   n_oeop, 1);
    check("ur_frames", frame_cnt, 1);

    // Resync: sop at sample 5, sop re-presented through ERR, frame completes.
    do_reset();
    clr_counts();
    frame(32'h300, 5);
    step(1, 1, 32'h400);
    step(1, 1, 32'h400);
    frame(32'h400, NPT);
    idle(LAT + 4);
    check("rs_errcnt", err_cnt, 1);
    check("rs_starts", n_start, 2);
    check("rs_dpv",    n_dpv, 21);
    check("rs_outv",   n_outv, 16);
    check("rs_frames", frame_cnt, 1);

    // Stray non-sop samples in IDLE.
    do_reset();
    clr_counts();
    for (int i = 0; i < 4; i++) step(1, 0, 32'hdead0000 + NB'(i));
    frame(32'h500, NPT);
    idle(LAT + 4);
    check("st_dpv",    n_dpv, 16);
    check("st_outv",   n_outv, 16);
    check("st_errcnt", err_cnt, 0);

    // Reset at sample 7, then a clean frame.
    do_reset();
    frame(32'h600, 7);
    do_reset();
    clr_counts();
    frame(32'h700, NPT);
    idle(LAT + 4);
    check("mr_outv",   n_outv, 16);
    check("mr_osop",   n_osop, 1);
    check("mr_frames", frame_cnt, 1);

    // Error counter saturation.
    do_reset();
    for (int i = 0; i < 260; i++) begin
      step(1, 1, NB'(i));
      step(0, 0, '0);
      step(0, 0, '0);
    end
    check("err_sat", err_cnt, 255);

    // Randomized stream mixing frames, gaps, underruns, resyncs, strays.
    do_reset();
    for (int it = 0; it < 60; it++) begin
      kind = $urandom_range(0, 9);
      len  = $urandom_range(1, NPT - 1);
      case (kind)
        0, 1, 2, 3, 4, 5: frame($urandom, NPT);
        6: idle($urandom_range(1, 3));
        7: begin frame($urandom, len); step(0, 0, '0); end
        8: begin frame($urandom, len); step(1, 1, $urandom); end
        default: step(1, 0, $urandom);
      endcase
    end
    idle(LAT + 4);
    check("rnd_idle_busy", busy, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
